// File: rtl/alu_mul_seq.sv
// Sequential unsigned WIDTHxWIDTH multiplier that borrows the shared execute-stage ALU.
// It runs one shift-and-add iteration per cycle, with a start/busy/done handshake.
module alu_mul_seq #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  OP_ADD  = 6'b100000,
  parameter logic [5:0]  OP_IDLE = 6'b100100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_dataA,
  output logic [WIDTH-1:0]     alu_dataB,
  output logic [5:0]           alu_Signal,
  input  logic [WIDTH-1:0]     alu_dataOut
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand, hi, lo;
  logic               accept;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  // The ALU exports no carry, so the carry-out of hi+b is rebuilt from the operand and sum MSBs.
  function automatic logic carry_from_msb(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    alu_dataA  = '0;
    alu_dataB  = '0;
    alu_Signal = OP_IDLE;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        alu_dataA  = hi;
        alu_dataB  = lo[0] ? mcand : '0;
        alu_Signal = OP_ADD;
        if (count == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign carry   = carry_from_msb(hi[WIDTH-1], alu_dataB[WIDTH-1], alu_dataOut[WIDTH-1]);
  assign shifted = {carry, alu_dataOut, lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand <= op_a;
        lo    <= op_b;
        hi    <= '0;
        count <= '0;
      end else if (state == RUN) begin
        {hi, lo} <= shifted;
        count    <= count + 1'b1;
        if (count == LAST) product <= shifted;
      end
    end
  end

endmodule
